// File: rtl/memshare_rqstaddr_gen_if.sv
// Request bus between the memShare read-address generator and the msgPass buffer.
// The generator drives valid/address as master; the buffer returns ready as slave.
interface memshare_rqstaddr_gen_if #(
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  rqst_valid;
    logic                  rqst_ready;
    logic [ADDR_WIDTH-1:0] rqst_addr;

    modport master (
        output rqst_valid,
        output rqst_addr,
        input  rqst_ready
    );

    modport slave (
        input  rqst_valid,
        input  rqst_addr,
        output rqst_ready
    );
endinterface

// File: rtl/memshare_rqstaddr_gen.sv
// Read-address generator for the msgPass buffer during SCU.memShare(): one request per handshake.
// Optional config checking of operand/rebase ranges is enabled by defining MEMSHARE_RQST_CFG_CHK_EN.
module memshare_rqstaddr_gen #(
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned OPERAND_WIDTH = 3,
    parameter int unsigned BUFF_DEPTH    = 32,
    parameter int unsigned ADDR_BASE     = 0,
    parameter int unsigned RQST_NUM      = 16,
    localparam int unsigned CNT_WIDTH    = $clog2(RQST_NUM + 1)
) (
    input  logic                     sys_clk,
    input  logic                     rstn,
    input  logic                     scu_begin_i,
    input  logic [OPERAND_WIDTH-1:0] increment_operand_i,
    input  logic                     drc_rebase_i,
    input  logic [ADDR_WIDTH-1:0]    drc_base_addr_i,
    memshare_rqstaddr_gen_if.master  rqst_if,
    output logic [CNT_WIDTH-1:0]     rqst_cnt_o,
    output logic                     scu_done_o,
    output logic                     cfg_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(BUFF_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(ADDR_BASE);
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(RQST_NUM - 1);

    state_e                  state_q;
    logic                    valid_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    done_q;

    logic                    handshake;
    logic [ADDR_WIDTH:0]     sum_d;
    logic [ADDR_WIDTH-1:0]   addr_d;

    assign handshake = valid_q & rqst_if.rqst_ready;

    // Operand is required to be below BUFF_DEPTH, so one conditional subtract wraps the sum.
    always_comb begin
        sum_d = {1'b0, addr_q} + (ADDR_WIDTH + 1)'(increment_operand_i);
        if (sum_d >= DEPTH_EXT) begin
            sum_d = sum_d - DEPTH_EXT;
        end
        addr_d = drc_rebase_i ? drc_base_addr_i : sum_d[ADDR_WIDTH-1:0];
    end

    // A restart wins over a coincident handshake: that request is not counted and no done fires.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= BASE_ADDR;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (scu_begin_i) begin
                state_q <= ISSUE;
                valid_q <= 1'b1;
                addr_q  <= BASE_ADDR;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        valid_q <= 1'b0;
                    end
                    ISSUE: begin
                        if (handshake) begin
                            cnt_q  <= cnt_q + CNT_WIDTH'(1);
                            addr_q <= addr_d;
                            if (cnt_q == LAST_CNT) begin
                                valid_q <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MEMSHARE_RQST_CFG_CHK_EN
    logic cfg_bad;
    logic err_q;

    always_comb begin
        if (drc_rebase_i) begin
            cfg_bad = (32'(drc_base_addr_i) >= BUFF_DEPTH);
        end else begin
            cfg_bad = (32'(increment_operand_i) >= BUFF_DEPTH);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (handshake && cfg_bad) begin
            err_q <= 1'b1;
        end
    end

    assign cfg_err_o = err_q;
`else
    assign cfg_err_o = 1'b0;
`endif

    assign rqst_if.rqst_valid = valid_q;
    assign rqst_if.rqst_addr  = addr_q;
    assign rqst_cnt_o         = cnt_q;
    assign scu_done_o         = done_q;

endmodule

// File: tb/tb_memshare_rqstaddr_gen.sv
// Directed self-checking bench for memshare_rqstaddr_gen (6-bit address, 32-entry buffer).
// Expected cfg_err_o depends on whether MEMSHARE_RQST_CFG_CHK_EN is defined.
module tb_memshare_rqstaddr_gen;

    localparam int unsigned AW = 6;
    localparam int unsigned OW = 3;
    localparam int unsigned CW = $clog2(16 + 1);
`ifdef MEMSHARE_RQST_CFG_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          sys_clk;
    logic          rstn;
    logic          scu_begin;
    logic [OW-1:0] operand;
    logic          rebase;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] cnt;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    memshare_rqstaddr_gen_if #(.ADDR_WIDTH(AW)) rq_if ();

    memshare_rqstaddr_gen #(
        .ADDR_WIDTH   (AW),
        .OPERAND_WIDTH(OW),
        .BUFF_DEPTH   (32),
        .ADDR_BASE    (0),
        .RQST_NUM     (16)
    ) dut (
        .sys_clk            (sys_clk),
        .rstn               (rstn),
        .scu_begin_i        (scu_begin),
        .increment_operand_i(operand),
        .drc_rebase_i       (rebase),
        .drc_base_addr_i    (base_addr),
        .rqst_if            (rq_if.master),
        .rqst_cnt_o         (cnt),
        .scu_done_o         (done),
        .cfg_err_o          (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_scu();
        scu_begin = 1'b1;
        tick();
        scu_begin = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        checks++; if (rq_if.rqst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", rq_if.rqst_valid); end
        checks++; if (rq_if.rqst_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rq_if.rqst_addr); end
        checks++; if (cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
        rstn = 1'b1;
        tick();
        checks++; if (rq_if.rqst_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b exp 0", rq_if.rqst_valid); end
    endtask

    task automatic test_linear();
        operand = 3'd1;
        rebase = 1'b0;
        rq_if.rqst_ready = 1'b1;
        start_scu();
        for (int i = 0; i < 16; i++) begin
            checks++; if (rq_if.rqst_valid !== 1'b1 || rq_if.rqst_addr !== 6'(i) || cnt !== 5'(i) || done !== 1'b0) begin
                errors++; $display("FAIL linear_%0d got v=%0b a=%0d c=%0d d=%0b exp v=1 a=%0d c=%0d d=0",
                                   i, rq_if.rqst_valid, rq_if.rqst_addr, cnt, done, i, i);
            end
            tick();
        end
        checks++; if (done !== 1'b1 || rq_if.rqst_valid !== 1'b0 || cnt !== 5'd16) begin
            errors++; $display("FAIL linear_done got d=%0b v=%0b c=%0d exp d=1 v=0 c=16", done, rq_if.rqst_valid, cnt);
        end
        tick();
        checks++; if (done !== 1'b0 || rq_if.rqst_valid !== 1'b0 || cnt !== 5'd16) begin
            errors++; $display("FAIL linear_after got d=%0b v=%0b c=%0d exp d=0 v=0 c=16", done, rq_if.rqst_valid, cnt);
        end
        tick();
        checks++; if (done !== 1'b0 || cnt !== 5'd16) begin
            errors++; $display("FAIL linear_hold got d=%0b c=%0d exp d=0 c=16", done, cnt);
        end
    endtask

    task automatic test_wrap_stall();
        logic [AW-1:0] exp_a [7] = '{6'd0, 6'd7, 6'd14, 6'd21, 6'd28, 6'd3, 6'd10};
        operand = 3'd7;
        rebase = 1'b0;
        rq_if.rqst_ready = 1'b1;
        start_scu();
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                rq_if.rqst_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    checks++; if (rq_if.rqst_valid !== 1'b1 || rq_if.rqst_addr !== 6'd14 || cnt !== 5'd2) begin
                        errors++; $display("FAIL stall_%0d got v=%0b a=%0d c=%0d exp v=1 a=14 c=2",
                                           k, rq_if.rqst_valid, rq_if.rqst_addr, cnt);
                    end
                end
                rq_if.rqst_ready = 1'b1;
            end
            checks++; if (rq_if.rqst_addr !== exp_a[i] || cnt !== 5'(i)) begin
                errors++; $display("FAIL wrap_%0d got a=%0d c=%0d exp a=%0d c=%0d", i, rq_if.rqst_addr, cnt, exp_a[i], i);
            end
            tick();
        end
    endtask

    task automatic test_rebase();
        logic [AW-1:0] exp_a [6] = '{6'd0, 6'd3, 6'd6, 6'd9, 6'd12, 6'd15};
        operand = 3'd3;
        base_addr = 6'd9;
        rebase = 1'b0;
        rq_if.rqst_ready = 1'b1;
        start_scu();
        for (int i = 0; i < 6; i++) begin
            checks++; if (rq_if.rqst_addr !== exp_a[i] || cnt !== 5'(i)) begin
                errors++; $display("FAIL rebase_%0d got a=%0d c=%0d exp a=%0d c=%0d", i, rq_if.rqst_addr, cnt, exp_a[i], i);
            end
            rebase = (i == 2);
            tick();
        end
        rebase = 1'b0;
    endtask

    task automatic test_restart();
        operand = 3'd1;
        rebase = 1'b0;
        rq_if.rqst_ready = 1'b1;
        start_scu();
        for (int i = 0; i < 5; i++) tick();
        checks++; if (rq_if.rqst_addr !== 6'd5 || cnt !== 5'd5) begin
            errors++; $display("FAIL restart_pre got a=%0d c=%0d exp a=5 c=5", rq_if.rqst_addr, cnt);
        end
        start_scu();
        for (int i = 0; i < 16; i++) begin
            checks++; if (rq_if.rqst_valid !== 1'b1 || rq_if.rqst_addr !== 6'(i) || cnt !== 5'(i) || done !== 1'b0) begin
                errors++; $display("FAIL restart_%0d got v=%0b a=%0d c=%0d d=%0b exp v=1 a=%0d c=%0d d=0",
                                   i, rq_if.rqst_valid, rq_if.rqst_addr, cnt, done, i, i);
            end
            tick();
        end
        checks++; if (done !== 1'b1 || cnt !== 5'd16) begin
            errors++; $display("FAIL restart_done got d=%0b c=%0d exp d=1 c=16", done, cnt);
        end
        // Final handshake coinciding with a restart must not produce done
        start_scu();
        for (int i = 0; i < 15; i++) tick();
        checks++; if (cnt !== 5'd15 || rq_if.rqst_addr !== 6'd15) begin
            errors++; $display("FAIL restart_last_pre got a=%0d c=%0d exp a=15 c=15", rq_if.rqst_addr, cnt);
        end
        start_scu();
        checks++; if (done !== 1'b0 || cnt !== 5'd0 || rq_if.rqst_valid !== 1'b1 || rq_if.rqst_addr !== 6'd0) begin
            errors++; $display("FAIL restart_last got d=%0b c=%0d v=%0b a=%0d exp d=0 c=0 v=1 a=0",
                               done, cnt, rq_if.rqst_valid, rq_if.rqst_addr);
        end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (cnt !== 5'd8) begin errors++; $display("FAIL abort_pre got c=%0d exp 8", cnt); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++; if (rq_if.rqst_valid !== 1'b0 || rq_if.rqst_addr !== 6'd0 || cnt !== 5'd0 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL abort_reset got v=%0b a=%0d c=%0d d=%0b e=%0b exp all 0",
                               rq_if.rqst_valid, rq_if.rqst_addr, cnt, done, err);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rq_if.rqst_valid !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL abort_idle_%0d got v=%0b d=%0b exp v=0 d=0", i, rq_if.rqst_valid, done);
            end
        end
    endtask

    task automatic test_cfg_err();
        operand = 3'd1;
        rebase = 1'b0;
        base_addr = 6'd40;
        rq_if.rqst_ready = 1'b1;
        start_scu();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cfg_pre got %0b exp 0", err); end
        rebase = 1'b1;
        tick();
        rebase = 1'b0;
        checks++; if (err !== EXP_ERR || rq_if.rqst_addr !== 6'd40) begin
            errors++; $display("FAIL cfg_set got e=%0b a=%0d exp e=%0b a=40", err, rq_if.rqst_addr, EXP_ERR);
        end
        tick();
        checks++; if (err !== EXP_ERR || rq_if.rqst_addr !== 6'd9) begin
            errors++; $display("FAIL cfg_wrap got e=%0b a=%0d exp e=%0b a=9", err, rq_if.rqst_addr, EXP_ERR);
        end
        start_scu();
        tick();
        checks++; if (err !== EXP_ERR) begin errors++; $display("FAIL cfg_sticky got %0b exp %0b", err, EXP_ERR); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cfg_clear got %0b exp 0", err); end
    endtask

    initial begin
        rstn = 1'b0;
        scu_begin = 1'b0;
        operand = '0;
        rebase = 1'b0;
        base_addr = '0;
        rq_if.rqst_ready = 1'b0;
        test_reset();
        test_linear();
        test_wrap_stall();
        test_rebase();
        test_restart();
        test_cfg_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
